// File: rtl/uart_baud_pkg.sv
// Shared constants and helpers for the NCO baud generator.
// Increment = round(2^acc_w * 16 * baud / clk_freq); DEF_INC is the value for the stock 50 MHz / 115200 build.
package uart_baud_pkg;

   function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                                input longint unsigned baud,
                                                input int unsigned     acc_w);
      longint unsigned num;
      num = (64'd1 << acc_w) * 64'd16 * baud;
      return (num + clk_freq / 64'd2) / clk_freq;
   endfunction

   localparam longint unsigned DEF_INC = calc_inc(64'd50_000_000, 64'd115_200, 16);

   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_nco_channel.sv
// One NCO channel: phase accumulator, live/pending increment and the 16x tick.
// UART_TICK_1X_EN adds a 4-bit sub-counter that produces a bit-rate tick_1x.
module uart_nco_channel
   import uart_baud_pkg::*;
#(
   parameter int                ACC_W   = 16,
   parameter logic [ACC_W-1:0]  RST_INC = ACC_W'(DEF_INC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             we,
   input  logic [ACC_W-1:0] wdata,
   output logic             upd_pend,
   output logic             tick_16x
`ifdef UART_TICK_1X_EN
   ,
   output logic             tick_1x
`endif
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] pending;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             apply_now;

   assign sum   = {1'b0, acc} + {1'b0, inc};
   assign carry = sum[ACC_W];

   // Safe points to swap the increment: the wrap edge, a stopped channel, or a zero
   // increment (which never wraps, so waiting for a carry would stall forever).
   assign apply_now = carry | ~en | (inc == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         inc      <= RST_INC;
         pending  <= RST_INC;
         upd_pend <= 1'b0;
         tick_16x <= 1'b0;
      end else begin
         if (en) begin
            acc      <= sum[ACC_W-1:0];
            tick_16x <= carry;
         end else begin
            acc      <= '0;
            tick_16x <= 1'b0;
         end

         if (we) pending <= wdata;

         if (apply_now) begin
            if (we)
               inc <= wdata;
            else if (upd_pend)
               inc <= pending;
            upd_pend <= 1'b0;
         end else if (we) begin
            upd_pend <= 1'b1;
         end
      end
   end

`ifdef UART_TICK_1X_EN
   logic [3:0] sub;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         sub     <= '0;
         tick_1x <= 1'b0;
      end else begin
         tick_1x <= carry && (sub == 4'hF);
         if (carry) sub <= sub + 4'd1;
      end
   end
`endif

endmodule

// File: rtl/uart_nco_baud_gen.sv
// Multi-channel fractional baud generator: decodes cfg writes onto NUM_CH NCO channels.
// Optional feature macro: UART_TICK_1X_EN (adds the tick_1x port and per-channel sub-counters).
module uart_nco_baud_gen
   import uart_baud_pkg::*;
#(
   parameter  int NUM_CH       = 2,
   parameter  int ACC_W        = 16,
   parameter  int CLK_FREQ     = 50_000_000,
   parameter  int DEFAULT_BAUD = 115200,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] upd_pend,
   output logic [NUM_CH-1:0] tick_16x
`ifdef UART_TICK_1X_EN
   ,
   output logic [NUM_CH-1:0] tick_1x
`endif
);

   localparam logic [ACC_W-1:0] RST_INC =
      ACC_W'(calc_inc(64'(CLK_FREQ), 64'(DEFAULT_BAUD), ACC_W));

   // Channel numbers at or above NUM_CH match no index, so such writes fall away.
   logic [NUM_CH-1:0] ch_we;

   always_comb begin
      ch_we = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_we && (int'(cfg_ch) == i)) ch_we[i] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      uart_nco_channel #(
         .ACC_W   (ACC_W),
         .RST_INC (RST_INC)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (ch_en[g]),
         .we       (ch_we[g]),
         .wdata    (cfg_inc),
         .upd_pend (upd_pend[g]),
         .tick_16x (tick_16x[g])
`ifdef UART_TICK_1X_EN
         ,
         .tick_1x  (tick_1x[g])
`endif
      );
   end

endmodule

// File: tb/tb_uart_nco_baud_gen.sv
// Bench for uart_nco_baud_gen: rate table with exact tick-time scoreboard, then
// hand sequences for live reprogramming, zero increment, write-on-carry and reset.
module tb_uart_nco_baud_gen;
   localparam int NUM_CH = 3;
   localparam int ACC_W  = 16;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] ch_en;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [ACC_W-1:0]  cfg_inc;
   logic [NUM_CH-1:0] upd_pend;
   logic [NUM_CH-1:0] tick_16x;
`ifdef UART_TICK_1X_EN
   logic [NUM_CH-1:0] tick_1x;
`endif

   uart_nco_baud_gen #(
      .NUM_CH       (NUM_CH),
      .ACC_W        (ACC_W),
      .CLK_FREQ     (50_000_000),
      .DEFAULT_BAUD (115200)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ch_en    (ch_en),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_inc  (cfg_inc),
      .upd_pend (upd_pend),
      .tick_16x (tick_16x)
`ifdef UART_TICK_1X_EN
      ,
      .tick_1x  (tick_1x)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [31:0] exp_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;
   bit  q_on   = 1'b1;
   int  n16, n1x, n16_1;
   bit  have_last0, have_last1;
   int  last0, last1, lo0, hi0, lo1, hi1;

   typedef struct {
      logic [15:0] inc;
      int          ncyc;
      int          exp_cnt;
      int          gap_lo;
      int          gap_hi;
      int          exp_1x;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
      end
   endtask

   // Tick m of a channel started from acc=0 appears ceil(m*2^ACC_W/inc) cycles after base.
   task automatic push_ticks(input int base, input int inc, input int win);
      longint j;
      if (inc == 0) return;
      for (int m = 1; m <= win; m++) begin
         j = (longint'(m) * (longint'(1) << ACC_W) + inc - 1) / inc;
         if (j > win) break;
         exp_q.push_back(32'(base + int'(j)));
      end
   endtask

   // One clock; all DUT sampling happens here on the falling edge.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      if (tick_16x[0] === 1'b1) begin
         n16++;
         if (q_on) begin
            if (exp_q.size() == 0) check("tick0_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("tick0_time", 32'(cyc), e);
            end
         end
         if (have_last0 && hi0 > 0) check_range("gap0", cyc - last0, lo0, hi0);
         last0 = cyc;
         have_last0 = 1'b1;
`ifdef UART_TICK_1X_EN
         check("tick1x_align", tick_1x[0], (n16 % 16) == 0);
`endif
      end
`ifdef UART_TICK_1X_EN
      else if (tick_1x[0] === 1'b1) check("tick1x_stray", tick_1x[0], 0);
      if (tick_1x[0] === 1'b1) n1x++;
`endif
      if (tick_16x[1] === 1'b1) begin
         n16_1++;
         if (have_last1 && hi1 > 0) check_range("gap1", cyc - last1, lo1, hi1);
         last1 = cyc;
         have_last1 = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      ch_en   = '0;
      cfg_we  = 1'b0;
      cfg_ch  = '0;
      cfg_inc = '0;
      step();
      step();
      reset = 1'b0;
      exp_q.delete();
      q_on = 1'b1;
      n16 = 0; n1x = 0; n16_1 = 0;
      have_last0 = 1'b0; have_last1 = 1'b0;
      lo0 = 0; hi0 = 0; lo1 = 0; hi1 = 0;
   endtask

   task automatic run_row(input vec_t v);
      int base;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = v.inc;
      step();
      cfg_we = 1'b0;
      check("row_pend_idle", upd_pend[0], 0);
      n16 = 0; n1x = 0; have_last0 = 1'b0;
      lo0 = v.gap_lo; hi0 = v.gap_hi;
      ch_en[0] = 1'b1;
      base = cyc;
      push_ticks(base, int'(v.inc), v.ncyc);
      repeat (v.ncyc) step();
      ch_en[0] = 1'b0;
      check("row_count", n16, v.exp_cnt);
      check("row_missing", exp_q.size(), 0);
`ifdef UART_TICK_1X_EN
      check("row_count_1x", n1x, v.exp_1x);
`endif
      step();
   endtask

   initial begin
      int  base;
      int  cnt;
      bit  found;

      vecs[0] = '{16'd2416,  65536, 2416, 27, 28, 151};
      vecs[1] = '{16'd4832,  8192,  604,  13, 14, 37};
      vecs[2] = '{16'd1208,  8192,  151,  54, 55, 9};
      vecs[3] = '{16'd32768, 1024,  512,  2,  2,  32};
      vecs[4] = '{16'd65535, 1024,  1023, 1,  2,  63};
      vecs[5] = '{16'd0,     1000,  0,    0,  0,  0};

      // reset state
      do_reset();
      check("rst_upd_pend", upd_pend, 0);
      check("rst_tick_16x", tick_16x, 0);
`ifdef UART_TICK_1X_EN
      check("rst_tick_1x", tick_1x, 0);
`endif

      // rate table; row 0 is the reset default over a full 2^16-cycle period
      do_reset();
      for (int i = 0; i < 6; i++) run_row(vecs[i]);

      // live reprogram of ch1 mid-period; ch0 keeps its exact schedule
      do_reset();
      lo0 = 27; hi0 = 28; lo1 = 27; hi1 = 28;
      ch_en = 3'b011;
      base = cyc;
      push_ticks(base, 2416, 300);
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (tick_16x[1] === 1'b1) begin found = 1'b1; break; end
      end
      check("ch1_first_tick", found, 1);
      repeat (5) step();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd4832;
      step();
      cfg_we = 1'b0;
      check("pend1_set", upd_pend[1], 1);
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (tick_16x[1] === 1'b1) begin found = 1'b1; break; end
         check("pend1_hold", upd_pend[1], 1);
      end
      check("ch1_apply_tick", found, 1);
      check("pend1_clear", upd_pend[1], 0);
      lo1 = 13; hi1 = 14;
      cnt = n16_1;
      while (cyc < base + 300) step();
      check_range("ch1_fast_ticks", n16_1 - cnt, 17, 19);
      check("pend0_untouched", upd_pend[0], 0);
      ch_en = '0;
      step();
      check("t2_missing", exp_q.size(), 0);

      // zero increment holds the channel; a later write takes effect at once
      do_reset();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd0;
      step();
      cfg_we = 1'b0;
      ch_en[0] = 1'b1;
      repeat (1000) step();
      check("zero_inc_ticks", n16, 0);
      cfg_we = 1'b1; cfg_inc = 16'd2416;
      push_ticks(cyc + 1, 2416, 60);
      step();
      cfg_we = 1'b0;
      check("zero_inc_pend", upd_pend[0], 0);
      lo0 = 27; hi0 = 28;
      repeat (59) step();
      check("t3_count", n16, 2);
      check("t3_missing", exp_q.size(), 0);

      // write landing on the ch0 carry cycle is applied directly
      do_reset();
      lo0 = 27; hi0 = 28;
      ch_en[0] = 1'b1;
      base = cyc;
      push_ticks(base, 2416, 82);
      repeat (81) step();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd1208;
      step();
      cfg_we = 1'b0;
      check("carry_wr_tick", last0, base + 82);
      check("carry_wr_pend", upd_pend[0], 0);
      check("t4_missing", exp_q.size(), 0);
      q_on = 1'b0;
      lo0 = 54; hi0 = 55;
      cnt = n16;
      for (int t = 0; t < 120; t++) begin
         step();
         check("carry_wr_pend_hold", upd_pend[0], 0);
      end
      check("t4_slow_ticks", n16 - cnt, 2);
      q_on = 1'b1;

      // reset mid-period with a pending write, then an out-of-range write
      do_reset();
      lo0 = 27; hi0 = 28;
      ch_en = 3'b111;
      base = cyc;
      push_ticks(base, 2416, 40);
      repeat (40) step();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd4832;
      step();
      cfg_we = 1'b0;
      check("t5_pend_before_rst", upd_pend[0], 1);
      check("t5_missing_pre", exp_q.size(), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_rst_pend", upd_pend, 0);
      check("t5_rst_tick", tick_16x, 0);
      n16 = 0; have_last0 = 1'b0;
      base = cyc;
      push_ticks(base, 2416, 100);
      for (int t = 1; t <= 100; t++) begin
         if (t == 50) begin cfg_we = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'd4832; end
         step();
         if (t == 50) begin
            cfg_we = 1'b0;
            check("bad_ch_ignored", upd_pend, 0);
         end
      end
      check("t5_count", n16, 3);
      check("t5_missing", exp_q.size(), 0);
      ch_en = '0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
